mem_loader: RTL

Upstream feeder for the six-entry 5-bit register bank `mem`. It accepts 5-bit words one at a time over a valid/ready handshake and stages them in slots d0..d5. Once six words are collected and the downstream `hold` is low, it issues a single-cycle `load` pulse so `mem` captures all six words in parallel. It also counts completed frames and supports a synchronous flush of a partial frame.

---
 rtl/mem_loader.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_loader.sv
// Staging front-end for the six-entry register bank: collects six words over a
// valid/ready handshake, then fires a one-cycle load once the bank is not held.
module mem_loader #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             flush,
    input  logic             hold,
    output logic             load,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] d4,
    output logic [WIDTH-1:0] d5,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [2:0]       fill_cnt
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t                     state_reg;
    logic [5:0][WIDTH-1:0]      slot_reg;
    logic [2:0]                 fill_cnt_reg;
    logic [CNT_W-1:0]           frame_cnt_reg;
    logic                       load_reg;
    logic                       accept;
    logic [5:0]                 wr_en;

    assign in_ready = (state_reg == FILL) && !flush;
    assign accept   = in_valid && in_ready;

    // One write enable per slot: only the slot addressed by fill_cnt changes.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_wr_en
            assign wr_en[gi] = accept && (fill_cnt_reg == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg     <= FILL;
            slot_reg      <= '0;
            fill_cnt_reg  <= 3'd0;
            frame_cnt_reg <= '0;
            load_reg      <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (wr_en[i]) begin
                    slot_reg[i] <= in_data;
                end
            end
            case (state_reg)
                FILL: begin
                    load_reg <= 1'b0;
                    if (flush) begin
                        fill_cnt_reg <= 3'd0;
                    end else if (accept) begin
                        fill_cnt_reg <= fill_cnt_reg + 3'd1;
                        if (fill_cnt_reg == 3'd5) begin
                            state_reg <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (flush) begin
                        fill_cnt_reg <= 3'd0;
                        state_reg    <= FILL;
                        load_reg     <= 1'b0;
                    end else if (!hold) begin
                        state_reg <= LOAD;
                        load_reg  <= 1'b1;
                    end
                end
                LOAD: begin
                    // Flush is ignored here so the bank always sees a complete frame.
                    load_reg      <= 1'b0;
                    fill_cnt_reg  <= 3'd0;
                    frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
                    state_reg     <= FILL;
                end
                default: begin
                    load_reg     <= 1'b0;
                    fill_cnt_reg <= 3'd0;
                    state_reg    <= FILL;
                end
            endcase
        end
    end

    assign load      = load_reg;
    assign fill_cnt  = fill_cnt_reg;
    assign frame_cnt = frame_cnt_reg;
    assign d0        = slot_reg[0];
    assign d1        = slot_reg[1];
    assign d2        = slot_reg[2];
    assign d3        = slot_reg[3];
    assign d4        = slot_reg[4];
    assign d5        = slot_reg[5];

endmodule
